// File: rtl/soft_ledda.sv
// soft_ledda: bus-programmable RGB PWM engine with prescaler, blink FSM
// and register read-back; duty values are double-buffered per period.
module soft_ledda #(
    parameter int DUTY_W = 8,
    parameter int PRE_W  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    input  logic [3:0] addr,
    input  logic       we,
    output logic       pwm_red,
    output logic       pwm_green,
    output logic       pwm_blue
);

    typedef enum logic [1:0] {
        S_DIS,
        S_ON,
        S_OFF
    } state_t;

    logic [DUTY_W-1:0] duty_r_q, duty_r_d;
    logic [DUTY_W-1:0] duty_g_q, duty_g_d;
    logic [DUTY_W-1:0] duty_b_q, duty_b_d;
    logic              en_q, en_d;
    logic [1:0]        pre_hi_q, pre_hi_d;
    logic [7:0]        pre_lo_q, pre_lo_d;
    logic [7:0]        ont_q, ont_d;
    logic [7:0]        oft_q, oft_d;

    logic [DUTY_W-1:0] act_r_q, act_r_d;
    logic [DUTY_W-1:0] act_g_q, act_g_d;
    logic [DUTY_W-1:0] act_b_q, act_b_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic              pwm_r_q, pwm_r_d;
    logic              pwm_g_q, pwm_g_d;
    logic              pwm_b_q, pwm_b_d;

    state_t            state_q;
    logic [7:0]        blink_cnt_q;

    logic [PRE_W-1:0]  pre_lim;
    logic              run;
    logic              tick;
    logic              period_end;
    logic              load;

    always_comb begin
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        en_d     = en_q;
        pre_hi_d = pre_hi_q;
        pre_lo_d = pre_lo_q;
        ont_d    = ont_q;
        oft_d    = oft_q;
        if (we) begin
            unique case (addr)
                4'h1: duty_r_d = DUTY_W'(dbw);
                4'h2: duty_g_d = DUTY_W'(dbw);
                4'h3: duty_b_d = DUTY_W'(dbw);
                4'h8: begin
                    en_d     = dbw[7];
                    pre_hi_d = dbw[1:0];
                end
                4'h9: pre_lo_d = dbw;
                4'hA: ont_d    = dbw;
                4'hB: oft_d    = dbw;
                default: ;
            endcase
        end
    end

    always_comb begin
        dbr = 8'h00;
        unique case (addr)
            4'h1: dbr = 8'(duty_r_q);
            4'h2: dbr = 8'(duty_g_q);
            4'h3: dbr = 8'(duty_b_q);
            4'h8: dbr = {en_q, 5'b0, pre_hi_q};
            4'h9: dbr = pre_lo_q;
            4'hA: dbr = ont_q;
            4'hB: dbr = oft_q;
            default: dbr = 8'h00;
        endcase
    end

    // Counters only run once the FSM has left DIS, so every enable
    // starts a fresh period from pwm_cnt = 0.
    always_comb begin
        pre_lim    = PRE_W'({pre_hi_q, pre_lo_q});
        run        = en_q && (state_q != S_DIS);
        tick       = run && (pre_cnt_q == pre_lim);
        period_end = tick && (pwm_cnt_q == '1);
        load       = period_end || (state_q == S_DIS && en_q);

        pre_cnt_d = pre_cnt_q + 1'b1;
        if (!run || tick) begin
            pre_cnt_d = '0;
        end

        pwm_cnt_d = pwm_cnt_q;
        if (!run) begin
            pwm_cnt_d = '0;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end

        act_r_d = load ? duty_r_q : act_r_q;
        act_g_d = load ? duty_g_q : act_g_q;
        act_b_d = load ? duty_b_q : act_b_q;

        pwm_r_d = (pwm_cnt_q < act_r_q) && (state_q == S_ON);
        pwm_g_d = (pwm_cnt_q < act_g_q) && (state_q == S_ON);
        pwm_b_d = (pwm_cnt_q < act_b_q) && (state_q == S_ON);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_r_q  <= '0;
            duty_g_q  <= '0;
            duty_b_q  <= '0;
            en_q      <= 1'b0;
            pre_hi_q  <= '0;
            pre_lo_q  <= '0;
            ont_q     <= '0;
            oft_q     <= '0;
            act_r_q   <= '0;
            act_g_q   <= '0;
            act_b_q   <= '0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            pwm_r_q   <= 1'b0;
            pwm_g_q   <= 1'b0;
            pwm_b_q   <= 1'b0;
        end else begin
            duty_r_q  <= duty_r_d;
            duty_g_q  <= duty_g_d;
            duty_b_q  <= duty_b_d;
            en_q      <= en_d;
            pre_hi_q  <= pre_hi_d;
            pre_lo_q  <= pre_lo_d;
            ont_q     <= ont_d;
            oft_q     <= oft_d;
            act_r_q   <= act_r_d;
            act_g_q   <= act_g_d;
            act_b_q   <= act_b_d;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_r_q   <= pwm_r_d;
            pwm_g_q   <= pwm_g_d;
            pwm_b_q   <= pwm_b_d;
        end
    end

    // OFT of zero in OFF means blinking was just switched off: resume ON.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_DIS;
            blink_cnt_q <= '0;
        end else if (!en_q) begin
            state_q     <= S_DIS;
            blink_cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_DIS: begin
                    state_q     <= S_ON;
                    blink_cnt_q <= '0;
                end
                S_ON: begin
                    if (period_end) begin
                        if (blink_cnt_q == ont_q && oft_q != 8'd0) begin
                            state_q     <= S_OFF;
                            blink_cnt_q <= '0;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 8'd1;
                        end
                    end
                end
                S_OFF: begin
                    if (period_end) begin
                        if (oft_q == 8'd0 || blink_cnt_q == oft_q - 8'd1) begin
                            state_q     <= S_ON;
                            blink_cnt_q <= '0;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= S_DIS;
                    blink_cnt_q <= '0;
                end
            endcase
        end
    end

    assign pwm_red   = pwm_r_q;
    assign pwm_green = pwm_g_q;
    assign pwm_blue  = pwm_b_q;

endmodule

// File: tb/tb_soft_ledda.sv
// Bench for soft_ledda: directed register/PWM/blink steps plus randomised
// configurations checked against an arithmetic waveform model.
module tb_soft_ledda;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dbw = 8'h00;
    logic [7:0] dbr;
    logic [3:0] addr = 4'h0;
    logic       we = 1'b0;
    logic       pwm_red;
    logic       pwm_green;
    logic       pwm_blue;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    soft_ledda #(.DUTY_W(8), .PRE_W(10)) dut (
        .clk(clk),
        .rst(rst),
        .dbw(dbw),
        .dbr(dbr),
        .addr(addr),
        .we(we),
        .pwm_red(pwm_red),
        .pwm_green(pwm_green),
        .pwm_blue(pwm_blue)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        dbw  = d;
        we   = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [7:0] e);
        addr = a;
        #1;
        chk(tag, {24'h0, dbr}, {24'h0, e});
    endtask

    // Returns at the negedge where pwm_red is first seen rising.
    task automatic sync_rise(input string tag);
        logic prev;
        bit   ok;
        prev = pwm_red;
        ok   = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (pwm_red && !prev) ok = 1'b1;
            prev = pwm_red;
        end
        chk(tag, {31'h0, ok}, 32'd1);
    endtask

    function automatic logic [7:0] map_exp(input logic [3:0] a,
                                           input logic [7:0] d);
        if (a == 4'h1 || a == 4'h2 || a == 4'h3 || a == 4'h9 ||
            a == 4'hA || a == 4'hB)
            return d;
        if (a == 4'h8)
            return d & 8'h83;
        return 8'h00;
    endfunction

    initial begin
        int r, g, b, run_len, max_run;
        int win[6];
        int exp_win[6];
        int pre, ont, oft, ncyc, n, k, cnt, per;
        logic [7:0] dr, dg, db;
        logic on;
        logic [2:0] exp3;

        // reset state
        #12;
        chk("rst_pwm", {29'h0, pwm_red, pwm_green, pwm_blue}, 32'd0);
        rd_chk("rst_rd_duty_r", 4'h1, 8'h00);
        rd_chk("rst_rd_cr0", 4'h8, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // register map and read-back
        for (int a = 0; a < 16; a++) wr(4'(a), 8'h5A);
        for (int a = 0; a < 16; a++)
            rd_chk($sformatf("map_rd_%0h", a), 4'(a), map_exp(4'(a), 8'h5A));
        wr(4'h8, 8'hFF);
        rd_chk("cr0_ff", 4'h8, 8'h83);
        wr(4'h8, 8'h00);

        // basic PWM, PRE=0
        wr(4'h9, 8'h00);
        wr(4'h1, 8'h40);
        wr(4'h2, 8'h00);
        wr(4'h3, 8'hFF);
        wr(4'h8, 8'h80);
        repeat (8) @(negedge clk);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < 256; i++) begin
            r += int'(pwm_red);
            g += int'(pwm_green);
            b += int'(pwm_blue);
            @(negedge clk);
        end
        chk("basic_red", r, 64);
        chk("basic_green", g, 0);
        chk("basic_blue", b, 255);

        // asynchronous reset while running
        sync_rise("rst_sync");
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_pwm", {29'h0, pwm_red, pwm_green, pwm_blue}, 32'd0);
        for (int a = 0; a < 16; a++)
            rd_chk($sformatf("rst_rd_%0h", a), 4'(a), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        r = 0;
        for (int i = 0; i < 300; i++) begin
            r += int'(pwm_red | pwm_green | pwm_blue);
            @(negedge clk);
        end
        chk("post_rst_idle", r, 0);

        // prescale PRE=3, duty 0x10
        wr(4'h9, 8'h03);
        wr(4'h1, 8'h10);
        wr(4'h8, 8'h80);
        sync_rise("pre_sync");
        r = 0; run_len = 0; max_run = 0;
        for (int i = 0; i < 1024; i++) begin
            r += int'(pwm_red);
            run_len = pwm_red ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            @(negedge clk);
        end
        chk("pre_high", r, 64);
        chk("pre_run", max_run, 64);

        // duty write mid-period takes effect next period
        wr(4'h8, 8'h00);
        wr(4'h9, 8'h00);
        wr(4'h1, 8'h20);
        wr(4'h8, 8'h80);
        sync_rise("glitch_sync");
        win[0] = 0; win[1] = 0;
        for (int i = 0; i < 512; i++) begin
            win[i / 256] += int'(pwm_red);
            if (i == 16) begin
                addr = 4'h1; dbw = 8'hC0; we = 1'b1;
            end
            if (i == 17) we = 1'b0;
            @(negedge clk);
        end
        chk("glitch_cur", win[0], 32);
        chk("glitch_next", win[1], 192);

        // blink ONT=1 OFT=2, OFT cleared during OFF
        wr(4'h8, 8'h00);
        wr(4'h1, 8'hFF);
        wr(4'hA, 8'h01);
        wr(4'hB, 8'h02);
        wr(4'h8, 8'h80);
        sync_rise("blink_sync");
        exp_win = '{255, 255, 0, 255, 255, 255};
        for (int w = 0; w < 6; w++) begin
            win[w] = 0;
            for (int i = 0; i < 256; i++) begin
                win[w] += int'(pwm_red);
                if (w == 2 && i == 100) begin
                    addr = 4'hB; dbw = 8'h00; we = 1'b1;
                end
                if (w == 2 && i == 101) we = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("blink_win%0d", w), win[w], exp_win[w]);
        end

        // randomised configurations against the waveform model
        for (int it = 0; it < 5; it++) begin
            pre = int'($urandom_range(0, 2));
            ont = int'($urandom_range(0, 2));
            oft = int'($urandom_range(0, 2));
            dr  = 8'($urandom_range(0, 255));
            dg  = 8'($urandom_range(0, 255));
            db  = 8'($urandom_range(0, 255));
            if (it == 0) begin
                dr = 8'h00; dg = 8'hFF; db = 8'h80;
            end
            wr(4'h8, 8'h00);
            wr(4'h9, 8'(pre));
            wr(4'h1, dr);
            wr(4'h2, dg);
            wr(4'h3, db);
            wr(4'hA, 8'(ont));
            wr(4'hB, 8'(oft));
            rd_chk("rnd_rd_duty_r", 4'h1, dr);
            rd_chk("rnd_rd_oft", 4'hB, 8'(oft));
            wr(4'h8, 8'h80);
            ncyc = 2 * (ont + 1 + oft) * 256 * (pre + 1) + 100;
            for (int j = 1; j <= ncyc; j++) begin
                @(negedge clk);
                exp3 = 3'b000;
                if (j >= 2) begin
                    n   = j - 2;
                    k   = n / (pre + 1);
                    cnt = k % 256;
                    per = k / 256;
                    on  = (oft == 0) || ((per % (ont + 1 + oft)) <= ont);
                    exp3 = {on && (cnt < int'(dr)),
                            on && (cnt < int'(dg)),
                            on && (cnt < int'(db))};
                end
                chk($sformatf("rnd%0d_c%0d", it, j),
                    {29'h0, pwm_red, pwm_green, pwm_blue}, {29'h0, exp3});
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
